fsm_rx_frame: RTL
=================

Name: fsm_rx_frame

Overview:
- Parametrised successor of the UART Rx core state machine.
- Sequences one asynchronous serial frame in order: start bit, data bits, optional parity bit, one or two stop bits.
- Assembles the data word (LSB first), checks parity and stop bits, and recovers from a stalled line with a watchdog.
- Sits in the Rx core between the Rx shift register (bit synch, sampled bit) and the baud-rate generator (acquisition strobe).

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- WDOG_LIMIT, 40, acquisition strobes allowed between consecutive Bit_Synch_i pulses before a timeout; legal range 2..255.
- TMR_EN, 1, 1 = state, bit counter and watchdog counter triplicated with bitwise 2-of-3 majority voting; 0 = single copy. Behaviour is otherwise identical.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- Rx_Synch_i  in  1  start-of-frame pulse from the shift register; honoured only in INTERVAL.
- Bit_Synch_i  in  1  one-cycle pulse marking the end of the current bit.
- RxBit_i  in  1  voted sample of the current bit; valid in the Bit_Synch_i cycle.
- AcqSig_i  in  1  acquisition strobe (16x baud) from the baud generator.
- ParityMode_i  in  2  00 none, 01 even, 10 odd, 11 none.
- StopBits_i  in  1  0 = one stop bit, 1 = two stop bits.
- State_o  out  5  one-hot state: INTERVAL 00001, STARTBIT 00010, DATABITS 00100, PARITYBIT 01000, STOPBIT 10000.
- BitCounter_o  out  4  index of the data bit currently being received.
- Data_o  out  DATA_BITS  last received word, LSB first on the line.
- DataValid_o  out  1  one-cycle pulse when a frame completes.
- ParityErr_o  out  1  parity mismatch; valid with DataValid_o.
- FrameErr_o  out  1  a stop bit sampled 0; valid with DataValid_o.
- Timeout_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous, active-low.
- Reset values: State_o = INTERVAL, BitCounter_o = 0, Data_o = 0; DataValid_o, ParityErr_o, FrameErr_o and Timeout_o = 0. Internal shift register, parity accumulator, stop counter and watchdog counter = 0.
- Reset asserted mid-frame aborts the frame with no DataValid_o.
- INTERVAL -> STARTBIT on Rx_Synch_i. Rx_Synch_i in any other state is ignored.
- STARTBIT -> DATABITS on Bit_Synch_i. The start-bit sample is not checked.
- DATABITS, on each Bit_Synch_i:
  - RxBit_i is shifted in at the MSB end (right shift), so the first bit received ends at bit 0.
  - The sample is XORed into the parity accumulator.
  - BitCounter_o increments.
  - When BitCounter_o == DATA_BITS-1 at that pulse: counter clears; next state is PARITYBIT if ParityMode_i is 01 or 10, else STOPBIT.
- BitCounter_o holds between pulses and is 0 outside DATABITS.
- PARITYBIT -> STOPBIT on Bit_Synch_i. Error = (acc XOR RxBit_i) != ParityMode_i[1], i.e. even requires even total, odd requires odd total.
- STOPBIT, on each Bit_Synch_i: RxBit_i == 0 sets the frame-error flag.
  - Last stop bit (first if StopBits_i = 0, second if 1): next state INTERVAL.
  - Same cycle: Data_o loads the assembled word, DataValid_o pulses, ParityErr_o and FrameErr_o present the frame's flags.
- Data_o holds until the next completed frame. Error outputs hold their value until the next DataValid_o.
- Configuration sampling: ParityMode_i and StopBits_i are sampled on leaving STARTBIT. Changes mid-frame are ignored.
- Latency: outputs are registered; DataValid_o asserts the cycle after the final Bit_Synch_i.
- Watchdog:
  - Counts AcqSig_i in every state except INTERVAL; cleared by Bit_Synch_i and on entry to STARTBIT.
  - Reaching WDOG_LIMIT: next state INTERVAL, Timeout_o pulses, no DataValid_o, all frame-internal registers cleared.
  - Bit_Synch_i coincident with expiry: Bit_Synch_i wins, no timeout.
- Illegal or voted-invalid state encoding (any non-one-hot value): next state INTERVAL, no output pulses.
- TMR_EN = 1:
  - Each of the three copies loads the same next value.
  - A single upset copy is outvoted and rewritten on the next clock.
  - Outputs are unaffected by a single-copy upset.

Test Plan:
- DATA_BITS = 8, mode none, 1 stop, bits 0x A5 LSB first, stop = 1 -> Data_o = 0xA5, DataValid_o high 1 cycle, both error flags 0, State_o back to 00001.
- Even parity, data 0x07, parity bit 0 -> ParityErr_o = 1. Repeat with parity bit 1 -> ParityErr_o = 0. Odd mode, same data, parity bit 0 -> ParityErr_o = 0.
- StopBits_i = 1, second stop sampled 0 -> FrameErr_o = 1 with DataValid_o. StopBits_i = 0 -> DataValid_o follows the first stop pulse.
- Stall after 3 data bits, 40 AcqSig_i strobes -> Timeout_o pulses once, State_o = 00001, no DataValid_o. 39 strobes then Bit_Synch_i -> frame continues normally.
- DATA_BITS = 5 and 9 builds: 0x15 and 0x1AB received correctly; BitCounter_o peaks at 4 and 8 respectively.
- TMR_EN = 1: force one state copy to 00100 while in INTERVAL -> State_o stays 00001, copy repaired next cycle. Async reset mid-DATABITS -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fsm_rx_frame.sv
// Serial frame receiver state machine: start, data (LSB first), optional
// parity, one or two stop bits, with a per-bit watchdog and optional
// triple-redundant control state.

// Control register with optional triplication. With TMR every copy loads the
// same next value and the output is the bitwise 2-of-3 vote, so a single
// upset copy is outvoted and rewritten on the next clock.
module fsm_rx_frame_treg #(
   parameter int             W   = 1,
   parameter logic [W-1:0]   RST = '0,
   parameter int             TMR = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   generate
      if (TMR != 0) begin : g_tmr
         logic [W-1:0] c0, c1, c2;
         // three copies, all loaded from the same next value
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               c0 <= RST;
               c1 <= RST;
               c2 <= RST;
            end else begin
               c0 <= d;
               c1 <= d;
               c2 <= d;
            end
         end
         assign q = (c0 & c1) | (c0 & c2) | (c1 & c2);
      end else begin : g_one
         logic [W-1:0] c0;
         // single copy
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) c0 <= RST;
            else      c0 <= d;
         end
         assign q = c0;
      end
   endgenerate
endmodule

module fsm_rx_frame #(
   parameter int DATA_BITS  = 8,
   parameter int WDOG_LIMIT = 40,
   parameter int TMR_EN     = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Rx_Synch_i,
   input  logic                 Bit_Synch_i,
   input  logic                 RxBit_i,
   input  logic                 AcqSig_i,
   input  logic [1:0]           ParityMode_i,
   input  logic                 StopBits_i,
   output logic [4:0]           State_o,
   output logic [3:0]           BitCounter_o,
   output logic [DATA_BITS-1:0] Data_o,
   output logic                 DataValid_o,
   output logic                 ParityErr_o,
   output logic                 FrameErr_o,
   output logic                 Timeout_o
);
   typedef enum logic [4:0] {
      S_INTERVAL = 5'b00001,
      S_START    = 5'b00010,
      S_DATA     = 5'b00100,
      S_PARITY   = 5'b01000,
      S_STOP     = 5'b10000
   } state_t;

   logic [4:0] st_q, st_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] wd_q, wd_d;
   state_t     st, st_n;

   // frame-internal datapath
   logic [DATA_BITS-1:0] sreg;
   logic                 acc, perr, ferr, stop_cnt, stop2;
   logic [1:0]           pmode;

   // control strobes from the next-state logic
   logic shift_en, par_chk, stop_smp, done, timeout, clr_frame, load_cfg, wd_run;

   fsm_rx_frame_treg #(.W(5), .RST(5'b00001), .TMR(TMR_EN)) u_st
      (.clk(clk), .rst(rst), .d(st_d), .q(st_q));
   fsm_rx_frame_treg #(.W(4), .RST(4'd0), .TMR(TMR_EN)) u_cnt
      (.clk(clk), .rst(rst), .d(cnt_d), .q(cnt_q));
   fsm_rx_frame_treg #(.W(8), .RST(8'd0), .TMR(TMR_EN)) u_wd
      (.clk(clk), .rst(rst), .d(wd_d), .q(wd_q));

   assign st           = state_t'(st_q);
   assign st_d         = st_n;
   assign State_o      = st_q;
   assign BitCounter_o = cnt_q;

   // next state, counters and datapath strobes; a voted state that is not
   // one-hot falls into the default arm and returns quietly to INTERVAL
   always_comb begin
      st_n      = st;
      cnt_d     = cnt_q;
      wd_d      = wd_q;
      shift_en  = 1'b0;
      par_chk   = 1'b0;
      stop_smp  = 1'b0;
      done      = 1'b0;
      timeout   = 1'b0;
      clr_frame = 1'b0;
      load_cfg  = 1'b0;
      wd_run    = 1'b0;
      case (st)
         S_INTERVAL: begin
            cnt_d = '0;
            wd_d  = '0;
            if (Rx_Synch_i) begin
               st_n      = S_START;
               clr_frame = 1'b1;
            end
         end
         S_START: begin
            wd_run = 1'b1;
            if (Bit_Synch_i) begin
               st_n     = S_DATA;
               load_cfg = 1'b1;
            end
         end
         S_DATA: begin
            wd_run = 1'b1;
            if (Bit_Synch_i) begin
               shift_en = 1'b1;
               if (cnt_q == 4'(DATA_BITS-1)) begin
                  cnt_d = '0;
                  st_n  = (pmode == 2'b01 || pmode == 2'b10) ? S_PARITY : S_STOP;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            wd_run = 1'b1;
            if (Bit_Synch_i) begin
               par_chk = 1'b1;
               st_n    = S_STOP;
            end
         end
         S_STOP: begin
            wd_run = 1'b1;
            if (Bit_Synch_i) begin
               stop_smp = 1'b1;
               if (stop_cnt == stop2) begin
                  done = 1'b1;
                  st_n = S_INTERVAL;
               end
            end
         end
         default: begin
            st_n      = S_INTERVAL;
            cnt_d     = '0;
            wd_d      = '0;
            clr_frame = 1'b1;
         end
      endcase
      // watchdog: a bit pulse always beats a coincident expiry
      if (wd_run) begin
         if (Bit_Synch_i) begin
            wd_d = '0;
         end else if (AcqSig_i) begin
            if (wd_q == 8'(WDOG_LIMIT-1)) begin
               timeout   = 1'b1;
               st_n      = S_INTERVAL;
               cnt_d     = '0;
               wd_d      = '0;
               clr_frame = 1'b1;
            end else begin
               wd_d = wd_q + 8'd1;
            end
         end
      end
   end

   // word assembly, parity/stop checking and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg        <= '0;
         acc         <= 1'b0;
         perr        <= 1'b0;
         ferr        <= 1'b0;
         stop_cnt    <= 1'b0;
         stop2       <= 1'b0;
         pmode       <= 2'b00;
         Data_o      <= '0;
         DataValid_o <= 1'b0;
         ParityErr_o <= 1'b0;
         FrameErr_o  <= 1'b0;
         Timeout_o   <= 1'b0;
      end else begin
         DataValid_o <= done;
         Timeout_o   <= timeout;
         if (clr_frame) begin
            sreg     <= '0;
            acc      <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            stop_cnt <= 1'b0;
         end
         if (load_cfg) begin
            pmode <= ParityMode_i;
            stop2 <= StopBits_i;
         end
         if (shift_en) begin
            sreg <= {RxBit_i, sreg[DATA_BITS-1:1]};
            acc  <= acc ^ RxBit_i;
         end
         if (par_chk) perr <= ((acc ^ RxBit_i) != pmode[1]);
         if (stop_smp) begin
            stop_cnt <= 1'b1;
            if (!RxBit_i) ferr <= 1'b1;
         end
         if (done) begin
            Data_o      <= sreg;
            ParityErr_o <= perr;
            FrameErr_o  <= ferr | ~RxBit_i;
         end
      end
   end
endmodule
